// File: rtl/wb_master_ctrl.sv
// Wishbone classic initiator: one read, write or read-modify-write per command, one response pulse each.
// Define WB_MASTER_TIMEOUT_EN to add a strobe watchdog that aborts a silent bus cycle with an error.
module wb_master_ctrl #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int GRANULE        = 8,
  parameter int SEL_WIDTH      = DATA_WIDTH / GRANULE,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [DATA_WIDTH-1:0] cmd_mask_i,
  output logic                  rsp_valid_o,
  output logic                  rsp_err_o,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [SEL_WIDTH-1:0]  sel_o,
  output logic                  we_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  input  logic                  ack_i,
  input  logic                  err_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_WR      = 3'd2;
  localparam logic [2:0] S_RMW_RD  = 3'd3;
  localparam logic [2:0] S_RMW_GAP = 3'd4;
  localparam logic [2:0] S_RMW_WR  = 3'd5;
  localparam logic [2:0] S_RESP    = 3'd6;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_RMW = 2'd2;

  logic [2:0]            state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;

  // Slave responses only count while a strobe is outstanding.
  logic bus_done, bus_err, tmo_hit;
  assign bus_done = stb_q & (ack_i | err_i);
  assign bus_err  = stb_q & err_i;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_hit = stb_q & ~ack_i & ~err_i & (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || !stb_q || bus_done || tmo_hit) tmo_q <= '0;
    else                                        tmo_q <= tmo_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [SEL_WIDTH-1:0] sel);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < SEL_WIDTH; i++) m[i*GRANULE +: GRANULE] = {GRANULE{sel[i]}};
    return m;
  endfunction

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
    rd_d        = rd_q;
    wdat_d      = wdat_q;
    mask_d      = mask_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && ready_q) begin
          adr_d  = cmd_adr_i;
          sel_d  = cmd_sel_i;
          wdat_d = cmd_dat_i;
          mask_d = cmd_mask_i;
          we_d   = (cmd_op_i == OP_WR);
          dat_d  = (cmd_op_i == OP_WR) ? cmd_dat_i : '0;
          case (cmd_op_i)
            OP_RD:  begin state_d = S_RD;     cyc_d = 1'b1; stb_d = 1'b1; end
            OP_WR:  begin state_d = S_WR;     cyc_d = 1'b1; stb_d = 1'b1; end
            OP_RMW: begin state_d = S_RMW_RD; cyc_d = 1'b1; stb_d = 1'b1; end
            default: begin
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_dat_d   = '0;
            end
          endcase
        end
      end

      S_RD, S_WR: begin
        if (bus_done) begin
          state_d     = S_RESP;
          {cyc_d, stb_d, we_d} = 3'b000;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_i;
          rsp_dat_d   = (state_q == S_RD && !err_i) ? (dat_i & lane_mask(sel_q)) : '0;
        end else if (tmo_hit) begin
          state_d     = S_RESP;
          {cyc_d, stb_d, we_d} = 3'b000;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
        end
      end

      S_RMW_RD: begin
        if (bus_err || tmo_hit) begin
          state_d     = S_RESP;
          {cyc_d, stb_d, we_d} = 3'b000;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_dat_d   = '0;
        end else if (bus_done) begin
          state_d = S_RMW_GAP;
          stb_d   = 1'b0;
          rd_d    = dat_i;
        end
      end

      S_RMW_GAP: begin
        state_d = S_RMW_WR;
        stb_d   = 1'b1;
        we_d    = 1'b1;
        dat_d   = (rd_q & ~mask_q) | (wdat_q & mask_q);
      end

      S_RMW_WR: begin
        if (bus_done || tmo_hit) begin
          state_d     = S_RESP;
          {cyc_d, stb_d, we_d} = 3'b000;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus_done ? err_i : 1'b1;
          rsp_dat_d   = bus_done ? rd_q : '0;
        end
      end

      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
      rd_q        <= '0;
      wdat_q      <= '0;
      mask_q      <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
      rd_q        <= rd_d;
      wdat_q      <= wdat_d;
      mask_q      <= mask_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = stb_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign sel_o       = sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_dat_o   = rsp_dat_q;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Bench for wb_master_ctrl: directed scenarios plus randomized commands against a transaction-level model.
module tb_wb_master_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [15:0] cmd_adr_i;
  logic [3:0]  cmd_sel_i;
  logic [31:0] cmd_dat_i;
  logic [31:0] cmd_mask_i;
  logic        rsp_valid_o;
  logic        rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic [15:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        cyc_o;
  logic        stb_o;
  logic        ack_i;
  logic        err_i;

  int n_checks = 0;
  int n_errors = 0;

  wb_master_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i), .cmd_mask_i(cmd_mask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_dat_o(rsp_dat_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .sel_o(sel_o), .we_o(we_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .err_i(err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every step leaves the bench 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] sel);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) if (sel[b]) r = r | (32'hFF << (8 * b));
    return r;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [15:0] adr, input logic [3:0] sel,
                       input logic [31:0] d, input logic [31:0] m);
    int n;
    n = 0;
    while (!cmd_ready_o && n < 20) begin tick(); n++; end
    check("ready_wait", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_adr_i   = adr;
    cmd_sel_i   = sel;
    cmd_dat_i   = d;
    cmd_mask_i  = m;
    tick();
    cmd_valid_i = 1'b0;
    cmd_dat_i   = $urandom;
    cmd_mask_i  = $urandom;
    check("ready_busy", cmd_ready_o, 0);
  endtask

  task automatic slave(input int w, input logic ack, input logic err, input logic [31:0] d);
    for (int i = 0; i < w; i++) begin
      tick();
      check("wait_bus", {cyc_o, stb_o, rsp_valid_o}, 3'b110);
    end
    ack_i = ack;
    err_i = err;
    dat_i = d;
    tick();
    ack_i = 1'b0;
    err_i = 1'b0;
    dat_i = $urandom;
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [15:0] adr, input logic [3:0] sel,
                         input logic [31:0] d, input logic [31:0] m,
                         input int w1, input logic [31:0] rdat, input logic e1, input logic both1,
                         input int w2, input logic e2, input logic spur);
    logic [31:0] exp_dat;
    logic        exp_err;
    issue(op, adr, sel, d, m);
    if (op == 2'd3) begin
      check("ill_bus", {cyc_o, stb_o}, 2'b00);
      exp_err = 1'b1;
      exp_dat = 32'h0;
    end else begin
      check("acc_ctl", {cyc_o, stb_o, we_o}, {2'b11, op == 2'd1});
      check("acc_adr", adr_o, adr);
      check("acc_sel", sel_o, sel);
      if (op == 2'd1) check("wr_dat", dat_o, d);
      slave(w1, !e1 || both1, e1, rdat);
      if (op == 2'd2 && !e1) begin
        check("gap", {cyc_o, stb_o, rsp_valid_o}, 3'b100);
        if (spur) begin ack_i = 1'b1; err_i = 1'b1; end
        tick();
        ack_i = 1'b0;
        err_i = 1'b0;
        check("rmw_wr_ctl", {cyc_o, stb_o, we_o}, 3'b111);
        check("rmw_wr_dat", dat_o, (rdat & ~m) | (d & m));
        check("rmw_wr_adr", {adr_o, sel_o}, {adr, sel});
        slave(w2, 1'b1, e2, $urandom);
        exp_err = e2;
        exp_dat = rdat;
      end else begin
        exp_err = e1;
        exp_dat = (op == 2'd0 && !e1) ? (rdat & lanes(sel)) : 32'h0;
      end
      check("end_bus", {cyc_o, stb_o, we_o}, 3'b000);
    end
    check("rsp_vld", rsp_valid_o, 1);
    check("rsp_err", rsp_err_o, exp_err);
    check("rsp_dat", rsp_dat_o, exp_dat);
    tick();
    check("rsp_pulse", {rsp_valid_o, cyc_o, stb_o}, 3'b000);
    check("idle_rdy", cmd_ready_o, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int          seen;
    logic [1:0]  r_op;
    logic [3:0]  r_sel;
    logic [15:0] r_adr;
    cmd_valid_i = 0; cmd_op_i = 0; cmd_adr_i = 0; cmd_sel_i = 0;
    cmd_dat_i = 0; cmd_mask_i = 0; dat_i = 0; ack_i = 0; err_i = 0;
    rst_i = 1'b1;
    tick();
    tick();
    check("rst_ctl", {cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o}, 5'b00000);
    check("rst_adr_sel", {adr_o, sel_o}, 20'h0);
    check("rst_dat", {dat_o, rsp_dat_o}, 64'h0);
    check("rst_rdy", cmd_ready_o, 1);
    rst_i = 1'b0;
    tick();

    run_txn(2'd0, 16'h0010, 4'hF, 32'h0, 32'h0, 2, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    run_txn(2'd1, 16'h0004, 4'h3, 32'h12345678, 32'h0, 1, 32'h0, 0, 0, 0, 0, 0);
    run_txn(2'd2, 16'h0020, 4'hF, 32'h00001234, 32'h0000FFFF, 1, 32'hAAAA5555, 0, 0, 1, 0, 1);
    run_txn(2'd2, 16'h0030, 4'hF, 32'h00001234, 32'h0000FFFF, 0, 32'hAAAA5555, 1, 0, 0, 0, 0);
    run_txn(2'd0, 16'h0040, 4'hF, 32'h0, 32'h0, 0, 32'h11111111, 1, 1, 0, 0, 0);
    run_txn(2'd3, 16'h0044, 4'hF, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0);
    run_txn(2'd0, 16'h0048, 4'h5, 32'h0, 32'h0, 0, 32'hCAFEF00D, 0, 0, 0, 0, 0);

    // Stray responses with no strobe must be ignored.
    ack_i = 1'b1; err_i = 1'b1;
    tick();
    tick();
    ack_i = 1'b0; err_i = 1'b0;
    check("stray_idle", {cyc_o, stb_o, rsp_valid_o, cmd_ready_o}, 4'b0001);

    issue(2'd0, 16'h0050, 4'hF, 32'h0, 32'h0);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst_mid", {cyc_o, stb_o, rsp_valid_o, cmd_ready_o}, 4'b0001);
    tick();
    check("rst_no_rsp", rsp_valid_o, 0);

    issue(2'd0, 16'h0060, 4'hF, 32'h0, 32'h0);
    seen = 0;
`ifdef WB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      if (!cyc_o || rsp_valid_o) seen++;
    end
    check("tmo_early", seen, 0);
    tick();
    check("tmo_abort", {cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o}, 5'b00011);
    tick();
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rsp_valid_o || !cyc_o || !stb_o) seen++;
    end
    check("hang_wait", seen, 0);
    check("hang_bus", {cyc_o, stb_o}, 2'b11);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
`endif

    for (int t = 0; t < 40; t++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_sel = 4'($urandom);
      r_adr = 16'($urandom);
      run_txn(r_op, r_adr, r_sel, $urandom, $urandom, $urandom_range(0, 3), $urandom,
              ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
              ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_master_ctrl.md
WB_MASTER_CTRL -- requirements
Module: wb_master_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 16, address width; DATA_WIDTH, 32, data width; GRANULE, 8, bits per select lane; SEL_WIDTH, DATA_WIDTH/GRANULE, select width; TIMEOUT_CYCLES, 16, watchdog limit.
REQ-002 Ports SHALL be: clk_i in 1, the single clock; rst_i in 1, synchronous active-high reset.
REQ-003 Command ports SHALL be: cmd_valid_i in 1, command offered; cmd_ready_o out 1, command accepted when both are high; cmd_op_i in 2, 0 = read, 1 = write, 2 = RMW, 3 = illegal; cmd_adr_i in ADDR_WIDTH; cmd_sel_i in SEL_WIDTH; cmd_dat_i in DATA_WIDTH, write data; cmd_mask_i in DATA_WIDTH, RMW bit mask.
REQ-004 Response ports SHALL be: rsp_valid_o out 1, one-cycle pulse; rsp_err_o out 1; rsp_dat_o out DATA_WIDTH, read data.
REQ-005 Wishbone classic initiator ports SHALL be: adr_o out ADDR_WIDTH; dat_o out DATA_WIDTH; dat_i in DATA_WIDTH; sel_o out SEL_WIDTH; we_o out 1; cyc_o out 1; stb_o out 1; ack_i in 1; err_i in 1.

Function
REQ-006 The states SHALL be IDLE, RD, WR, RMW_RD, RMW_GAP, RMW_WR and RESP. All outputs SHALL be registered.
REQ-007 cmd_ready_o SHALL be high only in IDLE.
REQ-008 When a command is accepted at edge N:
- adr_o, sel_o and we_o SHALL be driven from edge N.
- cyc_o and stb_o SHALL be high from edge N.
- we_o SHALL be 1 only for WR.
REQ-009 On a write, dat_o SHALL equal cmd_dat_i, held until the cycle ends.
REQ-010 The block SHALL sample ack_i and err_i only while stb_o is high. When both are high, err_i SHALL take priority.
REQ-011 In RD and WR, on ack_i or err_i at edge M:
- cyc_o, stb_o and we_o SHALL go low at edge M.
- rsp_valid_o SHALL be high for the one cycle after edge M.
- rsp_err_o SHALL equal err_i.
REQ-012 For a read with ack_i, rsp_dat_o SHALL equal dat_i with unselected lanes zeroed. It SHALL be 0 on a write or on an error.
REQ-013 RMW read phase: on ack_i at edge M, the block SHALL capture dat_i and drop stb_o while keeping cyc_o high.
REQ-014 RMW_GAP SHALL last exactly one cycle with stb_o low.
REQ-015 RMW write phase SHALL then assert stb_o and we_o with dat_o = (read & ~cmd_mask_i) | (cmd_dat_i & cmd_mask_i), using the same adr_o and sel_o.
REQ-016 On completion of the RMW write phase, rsp_dat_o SHALL equal the captured read data, and rsp_err_o SHALL equal the write-phase err_i.
REQ-017 An err_i during the RMW read phase SHALL end the cycle with cyc_o low and no write phase, and SHALL respond with rsp_err_o = 1 and rsp_dat_o = 0.
REQ-018 cmd_op_i = 3 SHALL produce no bus activity and SHALL raise rsp_valid_o with rsp_err_o = 1 one cycle after acceptance.
REQ-019 RESP SHALL last one cycle, then return to IDLE. Minimum command spacing SHALL be therefore 3 cycles for zero-wait-state RD and WR.
REQ-020 ack_i or err_i arriving while stb_o is low SHALL be ignored.

Reset
REQ-021 On rst_i at an edge, the block SHALL enter IDLE. cyc_o, stb_o, we_o, rsp_valid_o and rsp_err_o SHALL be 0. adr_o, dat_o, sel_o and rsp_dat_o SHALL be 0. cmd_ready_o SHALL be 1 after the edge.
REQ-022 Reset during a bus cycle SHALL drop cyc_o and stb_o at that edge, with no response issued.

Configuration
REQ-023 With WB_MASTER_TIMEOUT_EN defined, a counter SHALL run while stb_o is high. If TIMEOUT_CYCLES elapse with no ack_i or err_i, the block SHALL drop cyc_o, stb_o and we_o and respond with rsp_err_o = 1 (any phase, no RMW write).
REQ-024 Without WB_MASTER_TIMEOUT_EN, no counter SHALL exist and the block SHALL wait indefinitely.

Verification
REQ-025 Read: adr 0x0010, sel 0xF, slave acks after 2 wait states with dat_i 0xDEADBEEF -> rsp_dat_o = 0xDEADBEEF, rsp_err_o = 0, cyc_o low at the ack edge.
REQ-026 Write: adr 0x0004, sel 0x3, dat 0x12345678 -> dat_o = 0x12345678 and we_o = 1 until ack, then one rsp_valid_o pulse with rsp_err_o = 0.
REQ-027 RMW: read returns 0xAAAA5555, mask 0x0000FFFF, dat 0x00001234 -> write phase dat_o = 0xAAAA1234, cyc_o never drops between phases, rsp_dat_o = 0xAAAA5555.
REQ-028 RMW with err_i on the read phase -> no write strobe, rsp_err_o = 1; separately, ack_i and err_i together on a read -> rsp_err_o = 1.
REQ-029 op 3 -> cyc_o stays 0, rsp_err_o = 1; rst_i asserted mid-read -> cyc_o = 0 next edge, no rsp_valid_o.
REQ-030 With WB_MASTER_TIMEOUT_EN and a silent slave -> after 16 cycles cyc_o = 0 and rsp_err_o = 1; without the macro -> the block is still waiting after 100 cycles.
